// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
//   Bit-serial unsigned adder/subtractor. It handles one bit per clock, least
//   significant bit first. A subtraction that borrows gets a second serial
//   pass, which two's-complements the raw difference. As a result, Result
//   always holds a magnitude and Cout flags the negative case. Result, Cout
//   and Sub feed the downstream sign/overflow stage.
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   launch request, sampled only while idle
//   A, B    in   WIDTH-bit unsigned operands, captured on accept
//   Sub_in  in   operation select (0 = A+B, 1 = A-B), captured on accept
//   Result  out  sum (add) or |A-B| (sub), updated only on completion
//   Cout    out  carry-out (add) or borrow A<B (sub), updated on completion
//   Sub     out  operation of the completed result
//   busy    out  high while bits are being processed (CALC / NEGATE)
//   done    out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module serial_add_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub_in,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             Sub,
    output logic             busy,
    output logic             done
);

    // The extra counter bit keeps the terminal count clear of wrap-around.
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_NEGATE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] raw_q,    raw_d;
    logic             op_q,     op_d;
    logic             carry_q,  carry_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q,   cout_d;
    logic             subo_q,   subo_d;

    logic             b_bit;
    logic             in_bit;
    logic             sum_bit;
    logic             carry_bit;
    logic             last_bit;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        raw_d     = raw_q;
        op_d      = op_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        cout_d    = cout_q;
        subo_d    = subo_q;
        b_bit     = 1'b0;
        in_bit    = 1'b0;
        sum_bit   = 1'b0;
        carry_bit = 1'b0;
        last_bit  = (cnt_q == CW'(WIDTH - 1));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = Sub_in;
                    // Subtraction is A + ~B + 1: the +1 enters as carry-in on bit 0.
                    carry_d = Sub_in;
                    cnt_d   = '0;
                    raw_d   = '0;
                    state_d = S_CALC;
                end
            end

            S_CALC: begin
                b_bit     = op_q ? ~b_q[0] : b_q[0];
                sum_bit   = a_q[0] ^ b_bit ^ carry_q;
                carry_bit = (a_q[0] & b_bit) | (carry_q & (a_q[0] ^ b_bit));
                // The new bit enters at the MSB, so the result is LSB-aligned after WIDTH shifts.
                raw_d     = {sum_bit, raw_q[WIDTH-1:1]};
                a_d       = a_q >> 1;
                b_d       = b_q >> 1;
                carry_d   = carry_bit;
                cnt_d     = cnt_q + CW'(1);
                if (last_bit) begin
                    cnt_d = '0;
                    if (op_q && !carry_bit) begin
                        // A missing carry out of A + ~B + 1 means A < B, so negate the raw difference.
                        carry_d = 1'b1;
                        state_d = S_NEGATE;
                    end else begin
                        result_d = raw_d;
                        cout_d   = op_q ? ~carry_bit : carry_bit;
                        subo_d   = op_q;
                        state_d  = S_DONE;
                    end
                end
            end

            S_NEGATE: begin
                // Serial two's complement: invert each bit and ripple the +1 from bit 0.
                in_bit    = ~raw_q[0];
                sum_bit   = in_bit ^ carry_q;
                carry_bit = in_bit & carry_q;
                raw_d     = {sum_bit, raw_q[WIDTH-1:1]};
                carry_d   = carry_bit;
                cnt_d     = cnt_q + CW'(1);
                if (last_bit) begin
                    cnt_d    = '0;
                    result_d = raw_d;
                    cout_d   = 1'b1;
                    subo_d   = op_q;
                    state_d  = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            raw_q    <= '0;
            op_q     <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            subo_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            raw_q    <= raw_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            subo_q   <= subo_d;
        end
    end

    assign Result = result_q;
    assign Cout   = cout_q;
    assign Sub    = subo_q;
    assign busy   = (state_q == S_CALC) || (state_q == S_NEGATE);
    assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_add_sub.sv
module tb_serial_add_sub;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Sub_in;
    logic [W-1:0] Result;
    logic         Cout;
    logic         Sub;
    logic         busy;
    logic         done;

    int tests;
    int fails;
    bit chk_en;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .A      (A),
        .B      (B),
        .Sub_in (Sub_in),
        .Result (Result),
        .Cout   (Cout),
        .Sub    (Sub),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each operation is treated as a black box. Its answer comes from plain
    // integer arithmetic, and it finishes a fixed number of cycles after being
    // accepted. The result is published during the one-cycle done window.
    int m_rem;      // clock edges left until completion
    bit m_done;
    int m_res, m_cout, m_sub;
    int p_res, p_cout, p_sub;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  = 0;
            m_done = 0;
            m_res  = 0;
            m_cout = 0;
            m_sub  = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_done = 1;
                m_res  = p_res;
                m_cout = p_cout;
                m_sub  = p_sub;
            end
        end else if (start) begin
            int a, b;
            a = int'(A);
            b = int'(B);
            p_sub = int'(Sub_in);
            if (Sub_in) begin
                if (a < b) begin
                    p_res = b - a; p_cout = 1; m_rem = 2 * W;
                end else begin
                    p_res = a - b; p_cout = 0; m_rem = W;
                end
            end else begin
                p_res  = (a + b) % (1 << W);
                p_cout = (a + b) >> W;
                m_rem  = W;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",   int'(busy),   int'(m_rem > 0));
            check("done",   int'(done),   int'(m_done));
            check("Result", int'(Result), m_res);
            check("Cout",   int'(Cout),   m_cout);
            check("Sub",    int'(Sub),    m_sub);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic drive_edge();
        @(posedge clk);
        #2;
    endtask

    // Launch one operation, wait for done, and check against literal expectations.
    task automatic run_op(input string name, input int a, input int b, input bit s,
                          input int exp_res, input int exp_cout, input int exp_lat);
        int lat;
        drive_edge();
        A = W'(a); B = W'(b); Sub_in = s; start = 1'b1;
        drive_edge();
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); Sub_in = 1'($urandom);
        lat = 1;
        while (!done && lat < 4 * W) begin
            @(posedge clk);
            #1;
            if (!done) lat++;
        end
        if (!done) begin
            check({name, " timeout"}, 0, 1);
        end else begin
            check({name, " latency"}, lat, exp_lat);
            check({name, " Result"},  int'(Result), exp_res);
            check({name, " Cout"},    int'(Cout),   exp_cout);
            check({name, " Sub"},     int'(Sub),    int'(s));
        end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        start  = 1'b0;
        A = '0; B = '0; Sub_in = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset Result", int'(Result), 0);
        check("reset busy",   int'(busy),   0);
        check("reset done",   int'(done),   0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        run_op("add 5+3",  5, 3,  1'b0, 8,  0, W);
        run_op("add 9+8",  9, 8,  1'b0, 1,  1, W);
        run_op("sub 7-2",  7, 2,  1'b1, 5,  0, W);
        run_op("sub 2-7",  2, 7,  1'b1, 5,  1, 2 * W);
        run_op("sub 0-15", 0, 15, 1'b1, 15, 1, 2 * W);
        run_op("sub 9-0",  9, 0,  1'b1, 9,  0, W);

        // Equal operands, then a start pulse during busy that must be ignored.
        drive_edge();
        A = 4'd6; B = 4'd6; Sub_in = 1'b1; start = 1'b1;
        drive_edge();
        start = 1'b0;
        drive_edge();
        A = 4'd1; B = 4'd1; Sub_in = 1'b0; start = 1'b1;
        drive_edge();
        start = 1'b0;
        repeat (W + 4) drive_edge();
        check("eq Result hold", int'(Result), 0);
        check("eq Cout hold",   int'(Cout),   0);
        check("eq Sub hold",    int'(Sub),    1);
        check("eq idle",        int'(busy),   0);

        // Reset during the negate pass.
        drive_edge();
        A = 4'd2; B = 4'd7; Sub_in = 1'b1; start = 1'b1;
        drive_edge();
        start = 1'b0;
        repeat (W + 1) drive_edge();
        check("mid busy before rst", int'(busy), 1);
        chk_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst busy",   int'(busy),   0);
        check("rst done",   int'(done),   0);
        check("rst Result", int'(Result), 0);
        check("rst Cout",   int'(Cout),   0);
        check("rst Sub",    int'(Sub),    0);
        drive_edge();
        rst_n = 1'b1;
        chk_en = 1'b1;
        run_op("add 4+4", 4, 4, 1'b0, 8, 0, W);

        // Start held high continuously with changing operands.
        for (int i = 0; i < 60; i++) begin
            drive_edge();
            start = 1'b1;
            A = W'($urandom); B = W'($urandom); Sub_in = 1'($urandom);
        end
        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            drive_edge();
            start  = ($urandom_range(0, 2) == 0);
            A      = W'($urandom);
            B      = W'($urandom);
            Sub_in = 1'($urandom);
        end
        start = 1'b0;
        repeat (3 * W) drive_edge();
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
